// File: rtl/mcu_shared_bus.sv
// mcu_shared_bus: host-side responder for the MCU port-mapped external bus.
// Decodes port-2 strobes, latches a split address (port 4 low, port 3 high
// bits), and runs arbitrated single-byte read/write cycles on the shared RAM.

module mcu_shared_bus #(
    parameter int unsigned AW          = 11,
    parameter int unsigned GNT_TIMEOUT = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [4:0]    mcu_p2,
    input  logic [7:0]    mcu_p3_o,
    input  logic [7:0]    mcu_p4,
    output logic [7:0]    mcu_p3_i,
    output logic          mcu_busy,
    output logic          sh_req,
    input  logic          sh_gnt,
    output logic [AW-1:0] sh_addr,
    output logic [7:0]    sh_dout,
    output logic          sh_wr,
    input  logic [7:0]    sh_din,
    output logic          sem_flag,
    input  logic          sem_clr,
    output logic          bus_err
);

    localparam int unsigned CntW = (GNT_TIMEOUT < 1) ? 1 : $clog2(GNT_TIMEOUT + 1);
    localparam int unsigned HiW  = AW - 8;

    localparam int unsigned AleBit = 0;
    localparam int unsigned RdBit  = 1;
    localparam int unsigned WrBit  = 2;
    localparam int unsigned SemBit = 3;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAccess,
        StCapture,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        strb_q;
    logic              arm_q;
    logic [3:0]        fall;
    logic              start;
    logic              timeout;
    logic [HiW-1:0]    hi_q;
    logic [AW-1:0]     addr_q;
    logic [7:0]        data_q;
    logic              op_wr_q;
    logic [7:0]        p3i_q;
    logic              sem_q;
    logic              err_q;
    logic              unused_p2;

    // Port-2 bit 4 has no function on this bus.
    assign unused_p2 = mcu_p2[4];

    // Falling-edge detect. The first clock after reset only loads the history,
    // so strobes that are already low when reset releases never start a cycle.
    assign fall  = arm_q ? (strb_q & ~mcu_p2[3:0]) : 4'b0000;
    assign start = fall[RdBit] | fall[WrBit];

    // Strobe history and post-reset arm flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strb_q <= 4'hF;
            arm_q  <= 1'b0;
        end else begin
            strb_q <= mcu_p2[3:0];
            arm_q  <= 1'b1;
        end
    end

    // FSM state register and grant-timeout counter.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic; grant takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                if (sh_gnt) begin
                    state_d = StAccess;
                end else if (cnt_q == CntW'(GNT_TIMEOUT - 1)) begin
                    state_d = StDone;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAccess: begin
                state_d = op_wr_q ? StDone : StCapture;
            end
            StCapture: begin
                state_d = StDone;
            end
            StDone: begin
                // Wait for the strobe that opened the cycle to be released.
                if (op_wr_q ? mcu_p2[WrBit] : mcu_p2[RdBit]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs; decoded from state so reset removes them asynchronously.
    always_comb begin
        sh_req   = 1'b0;
        mcu_busy = 1'b0;
        sh_wr    = 1'b0;
        case (state_q)
            StReq: begin
                sh_req   = 1'b1;
                mcu_busy = 1'b1;
            end
            StAccess: begin
                sh_req   = 1'b1;
                mcu_busy = 1'b1;
                sh_wr    = op_wr_q;
            end
            StCapture: begin
                sh_req   = 1'b1;
                mcu_busy = 1'b1;
            end
            StDone: begin
                mcu_busy = 1'b1;
            end
            default: begin
                sh_req   = 1'b0;
            end
        endcase
    end

    // High-address latch, accepted in any state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
        end else if (fall[AleBit]) begin
            hi_q <= mcu_p3_o[HiW-1:0];
        end
    end

    // Cycle capture: address, write data and direction; write wins a tie.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            data_q  <= 8'h00;
            op_wr_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            addr_q  <= {hi_q, mcu_p4};
            data_q  <= mcu_p3_o;
            op_wr_q <= fall[WrBit];
        end
    end

    // Read-data return register; holds the last value between cycles.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p3i_q <= 8'hFF;
        end else if (timeout) begin
            p3i_q <= 8'hFF;
        end else if (state_q == StCapture) begin
            p3i_q <= sh_din;
        end
    end

    // Semaphore and sticky bus error; a set beats a coincident clear.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sem_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (fall[SemBit]) begin
                sem_q <= 1'b1;
            end else if (sem_clr) begin
                sem_q <= 1'b0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (sem_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign sh_addr  = addr_q;
    assign sh_dout  = data_q;
    assign mcu_p3_i = p3i_q;
    assign sem_flag = sem_q;
    assign bus_err  = err_q;

endmodule

// File: tb/tb_mcu_shared_bus.sv
// Directed bench for mcu_shared_bus with a behavioural shared-RAM model.

module tb_mcu_shared_bus;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [4:0]  mcu_p2;
    logic [7:0]  mcu_p3_o;
    logic [7:0]  mcu_p4;
    logic [7:0]  mcu_p3_i;
    logic        mcu_busy;
    logic        sh_req;
    logic        sh_gnt;
    logic [10:0] sh_addr;
    logic [7:0]  sh_dout;
    logic        sh_wr;
    logic [7:0]  sh_din;
    logic        sem_flag;
    logic        sem_clr;
    logic        bus_err;

    logic [7:0]  ram [0:2047];
    int          wr_cnt = 0;
    int          tests  = 0;
    int          fails  = 0;
    int          n;

    mcu_shared_bus #(.AW(11), .GNT_TIMEOUT(255)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .mcu_p2   (mcu_p2),
        .mcu_p3_o (mcu_p3_o),
        .mcu_p4   (mcu_p4),
        .mcu_p3_i (mcu_p3_i),
        .mcu_busy (mcu_busy),
        .sh_req   (sh_req),
        .sh_gnt   (sh_gnt),
        .sh_addr  (sh_addr),
        .sh_dout  (sh_dout),
        .sh_wr    (sh_wr),
        .sh_din   (sh_din),
        .sem_flag (sem_flag),
        .sem_clr  (sem_clr),
        .bus_err  (bus_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous RAM: read data one clock after address, write on sh_wr.
    always @(posedge clk_sys) begin
        sh_din <= ram[sh_addr];
        if (sh_wr) begin
            ram[sh_addr] <= sh_dout;
            wr_cnt       <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk_sys);
    endtask

    initial begin
        ram[11'h53C] <= 8'hA7;
        ram[11'h030] <= 8'h11;
        reset_n  = 1'b0;
        mcu_p2   = 5'h1F;
        mcu_p3_o = 8'h00;
        mcu_p4   = 8'h00;
        sh_gnt   = 1'b0;
        sem_clr  = 1'b0;
        step(2);
        chk("rst_p3i",  mcu_p3_i, 8'hFF);
        chk("rst_busy", mcu_busy, 0);
        chk("rst_req",  sh_req,   0);
        chk("rst_wr",   sh_wr,    0);
        chk("rst_addr", sh_addr,  0);
        chk("rst_dout", sh_dout,  0);
        chk("rst_sem",  sem_flag, 0);
        chk("rst_err",  bus_err,  0);
        reset_n = 1'b1;
        step(2);

        // 1: read 0x53C with grant after 3 clocks
        mcu_p3_o = 8'h05; mcu_p2 = 5'h1E;
        step(1);
        mcu_p2 = 5'h1F;
        step(1);
        mcu_p4 = 8'h3C; mcu_p2 = 5'h1D;
        step(1);
        chk("t1_addr", sh_addr, 11'h53C);
        chk("t1_req",  sh_req,  1);
        chk("t1_busy", mcu_busy, 1);
        step(2);
        sh_gnt = 1'b1;
        step(1);
        chk("t1_req_acc", sh_req, 1);
        step(1);
        chk("t1_p3i_early", mcu_p3i_snapshot(), 8'hFF);
        step(1);
        chk("t1_p3i",   mcu_p3_i, 8'hA7);
        chk("t1_req_done", sh_req, 0);
        chk("t1_busy_done", mcu_busy, 1);
        sh_gnt = 1'b0;
        mcu_p2 = 5'h1F;
        step(1);
        chk("t1_busy_end", mcu_busy, 0);

        // 2: write 0x010 = 0x5A, hi cleared first, immediate grant
        mcu_p3_o = 8'h00; mcu_p2 = 5'h1E;
        step(1);
        mcu_p2 = 5'h1F;
        step(1);
        n = wr_cnt;
        sh_gnt = 1'b1;
        mcu_p3_o = 8'h5A; mcu_p4 = 8'h10; mcu_p2 = 5'h1B;
        step(1);
        chk("t2_addr", sh_addr, 11'h010);
        chk("t2_dout", sh_dout, 8'h5A);
        chk("t2_wr_req", sh_wr, 0);
        step(1);
        chk("t2_wr_acc", sh_wr, 1);
        step(1);
        chk("t2_wr_done", sh_wr, 0);
        chk("t2_ram", ram[11'h010], 8'h5A);
        chk("t2_pulses", wr_cnt - n, 1);
        chk("t2_busy", mcu_busy, 1);
        sh_gnt = 1'b0;
        mcu_p2 = 5'h1F;
        step(1);
        chk("t2_busy_end", mcu_busy, 0);

        // 3: RD and WR fall together -> write only
        n = wr_cnt;
        sh_gnt = 1'b1;
        mcu_p3_o = 8'hC3; mcu_p4 = 8'h20; mcu_p2 = 5'h19;
        step(5);
        chk("t3_pulses", wr_cnt - n, 1);
        chk("t3_ram", ram[11'h020], 8'hC3);
        chk("t3_p3i", mcu_p3_i, 8'hA7);
        chk("t3_busy", mcu_busy, 1);
        sh_gnt = 1'b0;
        mcu_p2 = 5'h1F;
        step(1);
        chk("t3_busy_end", mcu_busy, 0);

        // 4: read with no grant -> timeout
        mcu_p4 = 8'h44; mcu_p2 = 5'h1D;
        step(1);
        n = 0;
        while (sh_req && n < 400) begin
            n++;
            step(1);
        end
        chk("t4_req_cycles", n, 255);
        chk("t4_err", bus_err, 1);
        chk("t4_p3i", mcu_p3_i, 8'hFF);
        chk("t4_busy", mcu_busy, 1);
        mcu_p2 = 5'h1F;
        step(1);
        chk("t4_busy_end", mcu_busy, 0);
        sem_clr = 1'b1;
        step(1);
        sem_clr = 1'b0;
        chk("t4_err_clr", bus_err, 0);

        // 5: semaphore set beats coincident clear
        mcu_p2 = 5'h17; sem_clr = 1'b1;
        step(1);
        chk("t5_sem_set", sem_flag, 1);
        mcu_p2 = 5'h1F; sem_clr = 1'b0;
        step(1);
        chk("t5_sem_hold", sem_flag, 1);
        sem_clr = 1'b1;
        step(1);
        sem_clr = 1'b0;
        chk("t5_sem_clr", sem_flag, 0);

        // 6: reset during write ACCESS
        n = wr_cnt;
        sh_gnt = 1'b1;
        mcu_p3_o = 8'h99; mcu_p4 = 8'h30; mcu_p2 = 5'h1B;
        step(2);
        chk("t6_wr_acc", sh_wr, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_wr_rst",   sh_wr,    0);
        chk("t6_req_rst",  sh_req,   0);
        chk("t6_busy_rst", mcu_busy, 0);
        chk("t6_addr_rst", sh_addr,  0);
        chk("t6_dout_rst", sh_dout,  0);
        chk("t6_p3i_rst",  mcu_p3_i, 8'hFF);
        step(1);
        chk("t6_ram", ram[11'h030], 8'h11);
        chk("t6_pulses", wr_cnt - n, 0);
        reset_n = 1'b1;
        step(4);
        chk("t6_no_req",  sh_req,   0);
        chk("t6_no_busy", mcu_busy, 0);
        chk("t6_no_wr",   wr_cnt - n, 0);
        mcu_p2 = 5'h1F; sh_gnt = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic [7:0] mcu_p3i_snapshot();
        return mcu_p3_i;
    endfunction

endmodule
